// File: rtl/controle_ula_if.sv
// Instruction handshake bundle for controle_ula.
// master offers the instruction; slave (the controller) accepts it.
interface controle_ula_if;
  logic        instr_valido;
  logic        instr_pronto;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [15:0] imediato;
  logic [4:0]  shamt_in;

  modport master (
    output instr_valido, opcode, funct,
    output reg_a, reg_b, imediato, shamt_in,
    input  instr_pronto
  );

  modport slave (
    input  instr_valido, opcode, funct,
    input  reg_a, reg_b, imediato, shamt_in,
    output instr_pronto
  );
endinterface

// File: rtl/controle_ula.sv
// ALU controller: accepts one instruction, decodes it, drives the ALU
// and captures the result with a fixed 4-state sequence.
module controle_ula (
  input  logic         clock,
  input  logic         reset,
  controle_ula_if.slave instr,
  output logic [5:0]   OpALU,
  output logic [31:0]  dado1,
  output logic [31:0]  dado2,
  output logic [4:0]   shamt,
  input  logic [31:0]  saida,
  input  logic         zero,
  output logic [31:0]  resultado,
  output logic         desvio,
  output logic         escreve,
  output logic         concluido,
  output logic         invalido
);

  localparam logic [1:0] OCIOSO     = 2'd0;
  localparam logic [1:0] DECODIFICA = 2'd1;
  localparam logic [1:0] EXECUTA    = 2'd2;
  localparam logic [1:0] CAPTURA    = 2'd3;

  logic [1:0]  estado;
  logic [5:0]  op_r;
  logic [5:0]  fn_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [15:0] imm_r;
  logic [4:0]  sh_r;

  logic        hs;
  logic        tipo_r;
  logic        fn_ok;
  logic        eh_desvio;
  logic        tipo_z;
  logic        tipo_s;
  logic        dec_ok;
  logic        dec_wr;
  logic [5:0]  dec_op;
  logic [31:0] dec_d1;
  logic [31:0] dec_d2;
  logic [4:0]  dec_sh;

  assign instr.instr_pronto = (estado == OCIOSO) && !reset;
  assign hs = instr.instr_valido && instr.instr_pronto;

  always_comb begin
    tipo_r    = (op_r == 6'd0);
    fn_ok     = (fn_r >= 6'd2 && fn_r <= 6'd8) ||
                (fn_r >= 6'd10 && fn_r <= 6'd17);
    eh_desvio = (op_r == 6'd25) || (op_r == 6'd26);
    tipo_z    = (op_r == 6'd28);
    tipo_s    = (op_r >= 6'd21) && (op_r <= 6'd27) && !eh_desvio;
    dec_ok    = 1'b0;
    dec_wr    = 1'b0;
    dec_op    = '0;
    dec_d1    = '0;
    dec_d2    = '0;
    dec_sh    = '0;
    unique case (1'b1)
      tipo_r && fn_ok: begin
        dec_ok = 1'b1;
        dec_wr = 1'b1;
        dec_op = fn_r;
        dec_d1 = a_r;
        dec_d2 = b_r;
        dec_sh = sh_r;
      end
      eh_desvio: begin
        dec_ok = 1'b1;
        dec_op = op_r;
        dec_d1 = a_r;
        dec_d2 = b_r;
      end
      tipo_z: begin
        dec_ok = 1'b1;
        dec_wr = 1'b1;
        dec_op = op_r;
        dec_d1 = a_r;
        dec_d2 = {16'h0000, imm_r};
      end
      tipo_s: begin
        dec_ok = 1'b1;
        dec_wr = (op_r != 6'd22);
        dec_op = op_r;
        dec_d1 = a_r;
        dec_d2 = {{16{imm_r[15]}}, imm_r};
      end
      default: ;
    endcase
  end

  // Decode stays valid through EXECUTA because the latched fields only
  // change on a handshake; outputs are captured on the edge into CAPTURA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      op_r      <= '0;
      fn_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      imm_r     <= '0;
      sh_r      <= '0;
      OpALU     <= '0;
      dado1     <= '0;
      dado2     <= '0;
      shamt     <= '0;
      resultado <= '0;
      desvio    <= 1'b0;
      escreve   <= 1'b0;
      concluido <= 1'b0;
      invalido  <= 1'b0;
    end else begin
      concluido <= 1'b0;
      invalido  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (hs) begin
            op_r   <= instr.opcode;
            fn_r   <= instr.funct;
            a_r    <= instr.reg_a;
            b_r    <= instr.reg_b;
            imm_r  <= instr.imediato;
            sh_r   <= instr.shamt_in;
            estado <= DECODIFICA;
          end
        end
        DECODIFICA: begin
          if (dec_ok) begin
            OpALU  <= dec_op;
            dado1  <= dec_d1;
            dado2  <= dec_d2;
            shamt  <= dec_sh;
            estado <= EXECUTA;
          end else begin
            concluido <= 1'b1;
            invalido  <= 1'b1;
            escreve   <= 1'b0;
            desvio    <= 1'b0;
            estado    <= CAPTURA;
          end
        end
        EXECUTA: begin
          resultado <= saida;
          desvio    <= eh_desvio && zero;
          escreve   <= dec_wr;
          concluido <= 1'b1;
          estado    <= CAPTURA;
        end
        default: begin
          OpALU  <= '0;
          dado1  <= '0;
          dado2  <= '0;
          shamt  <= '0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: doc/controle_ula.md
CONTROLE_ULA -- requirements
Module: controle_ula

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 The ports SHALL be as follows.
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- instr_valido  in  1  instruction offered
- instr_pronto  out  1  block can accept an instruction
- opcode  in  6  instruction opcode
- funct  in  6  R-type function field
- reg_a  in  32  first register operand
- reg_b  in  32  second register operand
- imediato  in  16  immediate field
- shamt_in  in  5  shift amount
- OpALU  out  6  operation code driven to the ALU
- dado1  out  32  ALU operand 1
- dado2  out  32  ALU operand 2
- shamt  out  5  ALU shift amount
- saida  in  32  ALU result
- zero  in  1  ALU flag
- resultado  out  32  captured result
- desvio  out  1  branch taken
- escreve  out  1  result is to be written to a register
- concluido  out  1  one-cycle completion pulse
- invalido  out  1  one-cycle unsupported-instruction pulse

Function
REQ-003 The FSM SHALL have four states, OCIOSO, DECODIFICA, EXECUTA and CAPTURA; reset SHALL force OCIOSO.
REQ-004 instr_pronto SHALL be 1 only in OCIOSO with reset low; a handshake SHALL occur when instr_valido and instr_pronto are both 1 on a rising edge.
REQ-005 On handshake, the block SHALL register opcode, funct, reg_a, reg_b, imediato and shamt_in, then go to DECODIFICA.
REQ-006 instr_valido SHALL be ignored in every state other than OCIOSO.
REQ-007 Decode for opcode 0 (R-type) SHALL set OpALU=funct when funct is in {2..8, 10..17}; it SHALL set dado1=reg_a, dado2=reg_b and shamt=shamt_in.
REQ-008 Decode for opcode 21..28 SHALL set OpALU=opcode, dado1=reg_a and shamt=0.
REQ-009 For opcode 21..27, dado2 SHALL be imediato sign-extended to 32 bits.
REQ-010 For opcode 28, dado2 SHALL be imediato zero-extended to 32 bits.
REQ-011 For opcodes 25 and 26, dado2 SHALL be reg_b, not the immediate.
REQ-012 Any other opcode, or an R-type funct outside the set in REQ-007, SHALL be invalid.
REQ-013 For a valid instruction, the FSM SHALL go DECODIFICA -> EXECUTA -> CAPTURA -> OCIOSO.
- OpALU, dado1, dado2 and shamt SHALL be registered and held stable through EXECUTA and CAPTURA.
REQ-014 In CAPTURA, saida SHALL be sampled into resultado.
- desvio SHALL be set to zero for opcodes 25 and 26, and to 0 otherwise.
- concluido SHALL be 1 for exactly that cycle.
REQ-015 escreve SHALL be 1 for R-type and opcodes 21, 23, 24, 27 and 28, and 0 for 22, 25 and 26.
- escreve SHALL be valid from CAPTURA until the next capture.
REQ-016 For an invalid instruction, the FSM SHALL go DECODIFICA -> CAPTURA without entering EXECUTA.
- In CAPTURA: concluido=1, invalido=1, escreve=0, desvio=0.
- resultado SHALL hold its previous value.
REQ-017 Latency SHALL be fixed: concluido on edge N+3 after a valid handshake at edge N, and N+2 for an invalid one.
- Maximum throughput SHALL be one instruction per 4 cycles.
REQ-018 In OCIOSO, OpALU, dado1, dado2 and shamt SHALL be 0.
REQ-019 resultado, desvio and escreve SHALL hold between captures.
- concluido and invalido SHALL be 0 outside CAPTURA.
REQ-020 The block SHALL perform no arithmetic itself beyond the immediate extension.

Reset
REQ-021 While reset is high, all outputs SHALL be 0 and all internal registers SHALL be cleared.
REQ-022 Reset asserted in any state SHALL abort the operation immediately.
- No concluido SHALL follow.
- instr_pronto SHALL be 1 on the first cycle after reset is released.

Verification
REQ-023 The bench SHALL connect the block to the team ALU and cover the following directed scenarios.
- opcode 0, funct 2, reg_a=5, reg_b=7 -> OpALU=2 in EXECUTA; at N+3: resultado=12, escreve=1, concluido pulse.
- opcode 23, reg_a=10, imediato=16'hFFFD -> dado2=32'hFFFFFFFD; resultado=7.
- opcode 25, reg_a=reg_b=3 -> desvio=1, escreve=0; then reg_b=4 -> desvio=0.
- opcode 28, imediato=16'h8001 -> dado2=32'h00008001; resultado=32'h80010000.
- opcode 40 after a prior resultado=12 -> at N+2: invalido=1, concluido=1; resultado stays 12; ALU ports stay 0.
- reset pulse during EXECUTA -> all outputs 0, no concluido; instr_pronto=1 after release; instr_valido held high while busy is not accepted.
